regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (WriteRg/RegWrite/WriteData) between two writeback sources:
- Source A: the in-order pipeline (ALU/load). Fixed priority, single-cycle.
- Source B: long-latency units (mult/div). Buffered in an internal FIFO.

It sits between the writeback stage and the register file. It also reports read-after-write hazards against queued B results so decode can stall.

Parameters:
DATA_W, 32, data width
ADDR_W, 5, register index width
DEPTH, 4, B queue entries (power of 2, >=2)
MAX_WAIT, 8, consecutive cycles the B head may be blocked by A before A is stalled

Ports:
Clock  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
A_Valid  in  1  pipeline writeback request
A_Rg  in  ADDR_W  pipeline destination register
A_Data  in  DATA_W  pipeline write data
A_Stall  out  1  A request not taken this cycle; pipeline must hold A_*
B_Valid  in  1  long-latency result valid
B_Ready  out  1  queue can accept (= !full)
B_Rg  in  ADDR_W  B destination register
B_Data  in  DATA_W  B write data
ReadRg1  in  ADDR_W  decode source register 1
ReadRg2  in  ADDR_W  decode source register 2
Busy1  out  1  ReadRg1 matches a live queued B entry
Busy2  out  1  ReadRg2 matches a live queued B entry
WriteRg  out  ADDR_W  to register file
RegWrite  out  1  to register file
WriteData  out  DATA_W  to register file

Behaviour:
- Clocking and reset:
  - One clock (Clock). Reset is synchronous and active-high.
  - Reset clears the queue, the live bits, the wait counter, WriteRg, RegWrite and WriteData to 0. B_Ready=1 and Busy1/2=0 in the cycle after reset.
  - Reset mid-operation discards queued entries; no write is issued for them.
- Outputs WriteRg/RegWrite/WriteData are registered. The selected request appears on them the cycle after it is taken, and the register file writes on the following edge.
- B enqueue:
  - Occurs when B_Valid && B_Ready.
  - B_Rg==0 is accepted but stored not-live. It is dropped at pop and never written.
  - Full queue: B_Ready=0 and the request is held by the source.
  - Enqueue and pop in the same cycle while full is allowed only if the pop is registered first. B_Ready uses the pre-pop count, which is conservative.
- Selection, evaluated each cycle:
  1. If wait_cnt==MAX_WAIT and the head is live: issue the head and set A_Stall=1 if A_Valid. wait_cnt resets to 0.
  2. Else if A_Valid: issue A. A_Stall=0. If A_Rg==0, RegWrite is driven 0 and no slot is consumed. If the head was live and blocked, wait_cnt increments.
  3. Else if the head is present: pop it. Issue it if live; drop it silently if not. wait_cnt=0.
  4. Else: RegWrite=0.
- Each cycle the head remains queued and A takes the port, wait_cnt++ (saturating at MAX_WAIT).
- Kill rule:
  - When A is issued with A_Rg!=0, every entry present in the queue before that edge with the same Rg has its live bit cleared. A is newer in program order.
  - An entry enqueued in the same cycle is not killed.
- Busy1/Busy2 are combinational: high if any live entry has Rg equal to the read register, and the read register is !=0.
- Dead entries still occupy slots until popped. They pop in one cycle each when A is idle.
- Pointers wrap modulo DEPTH. Count has ADDR width log2(DEPTH)+1.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: if A_Valid=0, the queue is empty and B_Valid with B_Rg!=0, B passes directly to the output registers without being stored. Latency from B request to RegWrite is 1 cycle.
- Undefined: B is always enqueued first. Minimum latency from B request to RegWrite is 2 cycles.

Test Plan:
- Reset, then A_Valid=1, A_Rg=2, A_Data=7 -> next cycle WriteRg=2, RegWrite=1, WriteData=7. With A_Rg=0 instead -> RegWrite=0.
- B_Valid with Rg=3, Data=1, queue empty, A idle -> RegWrite on Rg 3 with data 1 after 2 cycles (1 cycle with WB_BYPASS_EN). Busy1=1 for ReadRg1=3 while queued.
- Fill queue with 4 B entries, A idle off -> B_Ready=0 on the 5th request. After one pop, B_Ready=1. Entries drain in FIFO order.
- Queue B Rg=30 Data=FFFFFFFF, then A_Rg=30 Data=5 -> Busy drops the cycle after A issues. Only Rg 30 = 5 is written; the B entry is dropped.
- B head queued, A_Valid held high with Rg=10 -> after exactly 8 blocked cycles, A_Stall=1 for one cycle and the B head is written. A resumes the next cycle with its held data.
- Reset asserted with 3 entries queued -> no further RegWrite, Busy1/2=0, B_Ready=1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Arbitrates the register-file write port between the in-order
//             pipeline (source A, fixed priority) and long-latency units
//             (source B, buffered in a small FIFO). Reports RAW hazards
//             against live queued B results so decode can stall.
//  Options  : WB_BYPASS_EN - when defined, a B result arriving while A is
//             idle and the queue is empty goes straight to the write port.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              A_Valid,
    input  logic [ADDR_W-1:0] A_Rg,
    input  logic [DATA_W-1:0] A_Data,
    output logic              A_Stall,
    input  logic              B_Valid,
    output logic              B_Ready,
    input  logic [ADDR_W-1:0] B_Rg,
    input  logic [DATA_W-1:0] B_Data,
    input  logic [ADDR_W-1:0] ReadRg1,
    input  logic [ADDR_W-1:0] ReadRg2,
    output logic              Busy1,
    output logic              Busy2,
    output logic [ADDR_W-1:0] WriteRg,
    output logic              RegWrite,
    output logic [DATA_W-1:0] WriteData
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [c_CNT_W-1:0]  c_FULL     = c_CNT_W'(DEPTH);
    localparam logic [c_WAIT_W-1:0] c_MAX_WAIT = c_WAIT_W'(MAX_WAIT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE  = c_PTR_W'(1);

    // Queue storage; live_q is cleared on pop so only present entries are live
    logic [ADDR_W-1:0]   rg_q   [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic                live_q [DEPTH];
    logic [c_PTR_W-1:0]  rd_ptr_q;
    logic [c_PTR_W-1:0]  wr_ptr_q;
    logic [c_CNT_W-1:0]  count_q;
    logic [c_WAIT_W-1:0] wait_q;
    logic [c_WAIT_W-1:0] wait_d;

    logic              head_present;
    logic              head_live;
    logic              pop;
    logic              enq;
    logic              kill;
    logic              bypass;
    logic              issue_we;
    logic [ADDR_W-1:0] issue_rg;
    logic [DATA_W-1:0] issue_data;

    // Full check uses the pre-pop count, so a full queue never enqueues
    assign B_Ready = (count_q != c_FULL);
    assign enq     = B_Valid && B_Ready && !bypass;

    // Per-cycle write-port selection: starved B head, then A, then B head, then bypass
    always_comb begin
        head_present = (count_q != '0);
        head_live    = head_present && live_q[rd_ptr_q];
        pop          = 1'b0;
        kill         = 1'b0;
        bypass       = 1'b0;
        A_Stall      = 1'b0;
        issue_we     = 1'b0;
        issue_rg     = rg_q[rd_ptr_q];
        issue_data   = data_q[rd_ptr_q];
        wait_d       = wait_q;
        if ((wait_q == c_MAX_WAIT) && head_live) begin
            pop      = 1'b1;
            issue_we = 1'b1;
            A_Stall  = A_Valid;
            wait_d   = '0;
        end else if (A_Valid) begin
            issue_we   = (A_Rg != '0);
            issue_rg   = A_Rg;
            issue_data = A_Data;
            kill       = (A_Rg != '0);
            // A dead head cannot starve, so only a live head accumulates wait
            if (head_live && (wait_q != c_MAX_WAIT)) begin
                wait_d = wait_q + c_WAIT_ONE;
            end
        end else if (head_present) begin
            pop      = 1'b1;
            issue_we = live_q[rd_ptr_q];
            wait_d   = '0;
        end else begin
`ifdef WB_BYPASS_EN
            if (B_Valid && (B_Rg != '0)) begin
                bypass     = 1'b1;
                issue_we   = 1'b1;
                issue_rg   = B_Rg;
                issue_data = B_Data;
            end
`endif
        end
    end

    // Queue update: kill older same-register entries, pop head, append new B
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i] <= 1'b0;
                rg_q[i]   <= '0;
                data_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && live_q[i] && (rg_q[i] == A_Rg)) begin
                    live_q[i] <= 1'b0;
                end
            end
            if (pop) begin
                live_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q         <= rd_ptr_q + c_PTR_ONE;
            end
            // Same-cycle enqueue lands in a non-present slot, so it overrides any kill
            if (enq) begin
                rg_q[wr_ptr_q]   <= B_Rg;
                data_q[wr_ptr_q] <= B_Data;
                live_q[wr_ptr_q] <= (B_Rg != '0);
                wr_ptr_q         <= wr_ptr_q + c_PTR_ONE;
            end
            count_q <= count_q + c_CNT_W'(enq) - c_CNT_W'(pop);
            wait_q  <= wait_d;
        end
    end

    // Registered write port; address/data hold when no write is issued
    always_ff @(posedge Clock) begin
        if (Reset) begin
            WriteRg   <= '0;
            RegWrite  <= 1'b0;
            WriteData <= '0;
        end else begin
            RegWrite <= issue_we;
            if (issue_we) begin
                WriteRg   <= issue_rg;
                WriteData <= issue_data;
            end
        end
    end

    // RAW hazard lookup against live queued entries; register 0 never hazards
    always_comb begin
        Busy1 = 1'b0;
        Busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (rg_q[i] == ReadRg1) && (ReadRg1 != '0)) Busy1 = 1'b1;
            if (live_q[i] && (rg_q[i] == ReadRg2) && (ReadRg2 != '0)) Busy2 = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Self-checking bench for regfile_wb_arbiter. Directed scenarios
//             followed by randomized traffic, all checked every cycle against
//             a queue-based reference model of the arbitration rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic              clk;
    logic              Reset;
    logic              A_Valid;
    logic [ADDR_W-1:0] A_Rg;
    logic [DATA_W-1:0] A_Data;
    logic              A_Stall;
    logic              B_Valid;
    logic              B_Ready;
    logic [ADDR_W-1:0] B_Rg;
    logic [DATA_W-1:0] B_Data;
    logic [ADDR_W-1:0] ReadRg1;
    logic [ADDR_W-1:0] ReadRg2;
    logic              Busy1;
    logic              Busy2;
    logic [ADDR_W-1:0] WriteRg;
    logic              RegWrite;
    logic [DATA_W-1:0] WriteData;

    regfile_wb_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .Clock     (clk),
        .Reset     (Reset),
        .A_Valid   (A_Valid),
        .A_Rg      (A_Rg),
        .A_Data    (A_Data),
        .A_Stall   (A_Stall),
        .B_Valid   (B_Valid),
        .B_Ready   (B_Ready),
        .B_Rg      (B_Rg),
        .B_Data    (B_Data),
        .ReadRg1   (ReadRg1),
        .ReadRg2   (ReadRg2),
        .Busy1     (Busy1),
        .Busy2     (Busy2),
        .WriteRg   (WriteRg),
        .RegWrite  (RegWrite),
        .WriteData (WriteData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: queued B results in program order
    typedef struct {
        logic [ADDR_W-1:0] rg;
        logic [DATA_W-1:0] data;
        bit                live;
    } ent_t;

    ent_t              mq[$];
    int                mwait;
    bit                m_we;
    logic [ADDR_W-1:0] m_rg;
    logic [DATA_W-1:0] m_data;
    bit                m_stall;
    bit                m_ready;
    logic              obs_stall;

    int n_tests;
    int n_fail;
    int a_pct;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy(input logic [ADDR_W-1:0] r);
        if (r == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].live && mq[i].rg == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        mwait   = 0;
        m_we    = 1'b0;
        m_rg    = '0;
        m_data  = '0;
        m_stall = 1'b0;
        m_ready = 1'b1;
    endtask

    // One clock: check combinational outputs mid-cycle, advance model, check write port
    task automatic cycle();
        bit                hl;
        bit                acc;
        bit                byp;
        bit                nwe;
        logic [ADDR_W-1:0] nrg;
        logic [DATA_W-1:0] nd;
        ent_t              e;
        @(negedge clk);
        hl      = (mq.size() > 0) && mq[0].live;
        m_ready = (mq.size() < DEPTH);
        m_stall = A_Valid && hl && (mwait == MAX_WAIT);
        chk("a_stall", A_Stall, m_stall);
        chk("b_ready", B_Ready, m_ready);
        chk("busy1", Busy1, m_busy(ReadRg1));
        chk("busy2", Busy2, m_busy(ReadRg2));
        obs_stall = A_Stall;
        acc = B_Valid && m_ready;
        byp = 1'b0;
`ifdef WB_BYPASS_EN
        byp = !A_Valid && (mq.size() == 0) && B_Valid && (B_Rg != 0);
`endif
        nwe = 1'b0;
        nrg = m_rg;
        nd  = m_data;
        if (hl && mwait == MAX_WAIT) begin
            e = mq.pop_front();
            nwe = 1'b1; nrg = e.rg; nd = e.data;
            mwait = 0;
        end else if (A_Valid) begin
            if (A_Rg != 0) begin
                nwe = 1'b1; nrg = A_Rg; nd = A_Data;
                foreach (mq[i]) if (mq[i].rg == A_Rg) mq[i].live = 1'b0;
            end
            if (hl && mwait < MAX_WAIT) mwait++;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.live) begin
                nwe = 1'b1; nrg = e.rg; nd = e.data;
            end
            mwait = 0;
        end else if (byp) begin
            nwe = 1'b1; nrg = B_Rg; nd = B_Data;
        end
        if (acc && !byp) begin
            e.rg = B_Rg; e.data = B_Data; e.live = (B_Rg != 0);
            mq.push_back(e);
        end
        m_we = nwe; m_rg = nrg; m_data = nd;
        @(posedge clk);
        #1;
        chk("regwrite", RegWrite, m_we);
        if (m_we) begin
            chk("writerg", WriteRg, m_rg);
            chk("writedata", WriteData, m_data);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge clk);
        #1;
        Reset = 1'b0;
        model_reset();
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_writerg", WriteRg, 0);
        chk("rst_writedata", WriteData, 0);
        chk("rst_b_ready", B_Ready, 1);
        chk("rst_busy1", Busy1, 0);
        chk("rst_busy2", Busy2, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        a_pct   = 40;
        Reset   = 1'b1;
        A_Valid = 1'b0; A_Rg = '0; A_Data = '0;
        B_Valid = 1'b0; B_Rg = '0; B_Data = '0;
        ReadRg1 = '0;   ReadRg2 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // A write, then A to register 0
        A_Valid = 1'b1; A_Rg = 5'd2; A_Data = 32'd7;
        cycle();
        chk("t1_we", RegWrite, 1);
        chk("t1_rg", WriteRg, 2);
        chk("t1_data", WriteData, 7);
        A_Rg = 5'd0;
        cycle();
        chk("t1_rg0_we", RegWrite, 0);
        A_Valid = 1'b0;
        cycle();

        // Single B result with A idle
        ReadRg1 = 5'd3;
        B_Valid = 1'b1; B_Rg = 5'd3; B_Data = 32'd1;
        cycle();
        B_Valid = 1'b0;
`ifdef WB_BYPASS_EN
        chk("t2_byp_we", RegWrite, 1);
        chk("t2_byp_rg", WriteRg, 3);
        chk("t2_byp_data", WriteData, 1);
        chk("t2_byp_busy", Busy1, 0);
`else
        chk("t2_early_we", RegWrite, 0);
        chk("t2_busy_q", Busy1, 1);
        cycle();
        chk("t2_we", RegWrite, 1);
        chk("t2_rg", WriteRg, 3);
        chk("t2_data", WriteData, 1);
        chk("t2_busy_gone", Busy1, 0);
`endif
        ReadRg1 = 5'd0;

        // Fill the queue while A holds the port, then drain in order
        A_Valid = 1'b1; A_Rg = 5'd1; A_Data = 32'h11;
        B_Valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            B_Rg = ADDR_W'(4 + i); B_Data = 32'h100 + i;
            cycle();
        end
        B_Rg = 5'd8; B_Data = 32'h108;
        chk("t3_full", B_Ready, 0);
        cycle();
        A_Valid = 1'b0;
        cycle();
        chk("t3_first", WriteRg, 4);
        chk("t3_ready_after_pop", B_Ready, 1);
        cycle();
        B_Valid = 1'b0;
        chk("t3_second", WriteRg, 5);
        for (int k = 6; k <= 8; k++) begin
            cycle();
            chk("t3_order", WriteRg, k);
        end
        cycle();

        // Newer A write kills an older queued B to the same register
        A_Valid = 1'b1; A_Rg = 5'd0;
        B_Valid = 1'b1; B_Rg = 5'd30; B_Data = 32'hFFFF_FFFF;
        ReadRg1 = 5'd30;
        cycle();
        B_Valid = 1'b0;
        chk("t4_busy_q", Busy1, 1);
        A_Rg = 5'd30; A_Data = 32'd5;
        cycle();
        chk("t4_busy_killed", Busy1, 0);
        chk("t4_we", RegWrite, 1);
        chk("t4_rg", WriteRg, 30);
        chk("t4_data", WriteData, 5);
        A_Valid = 1'b0;
        cycle();
        chk("t4_dead_drop", RegWrite, 0);
        cycle();
        ReadRg1 = 5'd0;

        // Starvation limit: B head forces through after MAX_WAIT blocked cycles
        A_Valid = 1'b1; A_Rg = 5'd0;
        B_Valid = 1'b1; B_Rg = 5'd12; B_Data = 32'hAB;
        cycle();
        B_Valid = 1'b0;
        A_Rg = 5'd10; A_Data = 32'h55;
        for (int k = 0; k < MAX_WAIT; k++) begin
            cycle();
            chk("t5_a_taken", obs_stall, 0);
            chk("t5_a_rg", WriteRg, 10);
        end
        cycle();
        chk("t5_stall", obs_stall, 1);
        chk("t5_b_rg", WriteRg, 12);
        chk("t5_b_data", WriteData, 32'hAB);
        cycle();
        chk("t5_resume_stall", obs_stall, 0);
        chk("t5_resume_rg", WriteRg, 10);
        chk("t5_resume_data", WriteData, 32'h55);
        A_Valid = 1'b0;
        cycle();

        // Reset with three queued entries discards them
        A_Valid = 1'b1; A_Rg = 5'd0;
        B_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            B_Rg = ADDR_W'(20 + i); B_Data = i;
            cycle();
        end
        B_Valid = 1'b0;
        ReadRg1 = 5'd20; ReadRg2 = 5'd22;
        #1;
        chk("t6_busy1_pre", Busy1, 1);
        chk("t6_busy2_pre", Busy2, 1);
        do_reset();
        A_Valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t6_no_write", RegWrite, 0);
        end

        // Randomized traffic; sources hold requests while stalled or not ready
        for (int n = 0; n < 600; n++) begin
            if (n % 100 == 0) a_pct = ((n / 100) % 2 == 1) ? 95 : 40;
            if (!(A_Valid && m_stall)) begin
                A_Valid = ($urandom_range(0, 99) < a_pct);
                A_Rg    = ADDR_W'($urandom_range(0, 7));
                A_Data  = $urandom;
            end
            if (!(B_Valid && !m_ready)) begin
                B_Valid = ($urandom_range(0, 99) < 40);
                B_Rg    = ADDR_W'($urandom_range(0, 7));
                B_Data  = $urandom;
            end
            ReadRg1 = ADDR_W'($urandom_range(0, 7));
            ReadRg2 = ADDR_W'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
